// File: rtl/alu_seq.sv
// alu_seq: single-operation sequential ALU with a bit-serial shifter and valid/ready handshakes
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flags
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic             r_left;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_n;
    logic             w_shift;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [WIDTH-1:0] w_next;
    logic             w_out;

    assign w_sum    = {1'b0, A} + {1'b0, B};
    assign w_diff   = {1'b0, A} - {1'b0, B};
    assign w_n      = B[SHW-1:0];
    assign w_shift  = (ALUControl == OP_SHL || ALUControl == OP_SHR) && (w_n != '0);
    assign w_next   = r_left ? {r_work[WIDTH-2:0], 1'b0} : {1'b0, r_work[WIDTH-1:1]};
    assign w_out    = r_left ? r_work[WIDTH-1] : r_work[0];
    assign in_ready = (r_state == S_IDLE) && rst_n;
    assign out_valid = (r_state == S_DONE);
    assign Result   = r_result;
    assign Flags    = r_flags;

    // Single-cycle result and C/V flags; shifts by zero pass A through with C=0
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = ~w_diff[WIDTH];
                w_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  w_res = A & B;
            OP_OR:   w_res = A | B;
            OP_XOR:  w_res = A ^ B;
            OP_SHL,
            OP_SHR:  w_res = A;
            default: w_res = '0;
        endcase
    end

    // Handshake FSM; Result/Flags only change when entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_cnt    <= '0;
            r_left   <= 1'b0;
            r_result <= '0;
            r_flags  <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid && in_ready) begin
                    if (w_shift) begin
                        r_work  <= A;
                        r_cnt   <= w_n;
                        r_left  <= (ALUControl == OP_SHL);
                        r_state <= S_SHIFT;
                    end else begin
                        r_result <= w_res;
                        r_flags  <= {w_res[WIDTH-1], w_res == '0, w_c, w_v};
                        r_state  <= S_DONE;
                    end
                end
                S_SHIFT: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_result <= w_next;
                        r_flags  <= {w_next[WIDTH-1], w_next == '0, w_out, 1'b0};
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: if (out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   ALUControl = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Result;
    logic [3:0]   Flags;

    int n_chk = 0;
    int n_pass = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .Flags(Flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: plain integer arithmetic on the opcode semantics
    function automatic void model(input int a, input int b, input int op,
                                  output logic [W-1:0] r, output logic [3:0] f, output int lat);
        int res, c, v, n, sa, sb, s;
        n = b % W;
        c = 0;
        v = 0;
        lat = 1;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0: begin res = a + b; c = (res > 255); s = sa + sb; v = (s > 127 || s < -128); end
            1: begin res = a - b; c = (a >= b); s = sa - sb; v = (s > 127 || s < -128); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = a << n; c = (n == 0) ? 0 : (a >> (W - n)) & 1; lat = n + 1; end
            6: begin res = a >> n; c = (n == 0) ? 0 : (a >> (n - 1)) & 1; lat = n + 1; end
            default: res = 0;
        endcase
        res = res & 255;
        r = res[W-1:0];
        f = {r[W-1], r == 0, c[0], v[0]};
    endfunction

    // One full transaction; bp > 0 adds backpressure cycles with a competing request
    task automatic run_op(input int a, input int b, input int op, input int bp, input string tag);
        logic [W-1:0] er, pr;
        logic [3:0]   ef, pf;
        int           el, lat;
        model(a, b, op, er, ef, el);
        @(negedge clk);
        chk({tag, ".rdy"}, in_ready, 1);
        pr = Result;
        pf = Flags;
        A = a[W-1:0];
        B = b[W-1:0];
        ALUControl = op[2:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        ALUControl = 3'($urandom);
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (out_valid || lat > 3 * W) break;
            chk({tag, ".hold_r"}, Result, pr);
            chk({tag, ".hold_f"}, Flags, pf);
        end
        chk({tag, ".lat"}, lat, el);
        chk({tag, ".res"}, Result, er);
        chk({tag, ".flags"}, Flags, ef);
        if (bp > 0) begin
            in_valid = 1'b1;
            repeat (bp) begin
                @(negedge clk);
                chk({tag, ".bp_vld"}, out_valid, 1);
                chk({tag, ".bp_rdy"}, in_ready, 0);
                chk({tag, ".bp_res"}, Result, er);
                chk({tag, ".bp_flags"}, Flags, ef);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".drop"}, out_valid, 0);
        chk({tag, ".idle"}, in_ready, 1);
        chk({tag, ".keep"}, Result, er);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst.res", Result, 0);
        chk("rst.flags", Flags, 0);
        chk("rst.vld", out_valid, 0);
        chk("rst.rdy", in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.rdy_after", in_ready, 1);

        run_op(8'h0F, 8'h03, 0, 0, "add");
        run_op(8'h03, 8'h0F, 1, 0, "sub_neg");
        run_op(8'h80, 8'h01, 1, 0, "sub_ovf");
        run_op(8'h0F, 8'h03, 5, 0, "shl3");
        run_op(8'h81, 8'h01, 5, 0, "shl1");
        run_op(8'h0F, 8'h00, 6, 0, "shr0");
        run_op(8'hFF, 8'h01, 0, 0, "add_wrap");
        run_op(8'h5A, 8'h33, 7, 0, "zero");
        run_op(8'h0F, 8'h03, 2, 0, "and");
        run_op(8'h0F, 8'h03, 3, 0, "or");
        run_op(8'h0F, 8'h03, 4, 5, "xor_bp");
        run_op(8'hB5, 8'h07, 6, 0, "shr7");
        run_op(8'hB5, 8'h07, 5, 3, "shl7_bp");

        for (int i = 0; i < 40; i++)
            run_op($urandom_range(255), $urandom_range(255), $urandom_range(7), $urandom_range(2), "rnd");

        run_op(8'h3C, 8'h11, 0, 0, "pre_rst");
        @(negedge clk);
        A = 8'hFF;
        B = 8'h07;
        ALUControl = 3'b101;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort.busy", in_ready, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.res", Result, 0);
        chk("abort.flags", Flags, 0);
        chk("abort.vld", out_valid, 0);
        chk("abort.rdy", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort.rdy_after", in_ready, 1);
        repeat (10) begin
            @(negedge clk);
            chk("abort.no_vld", out_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: WIDTH, default 8, operand/result width in bits (legal values: any power of two, at least 4).
REQ-003 Derived localparam: SHW = clog2(WIDTH), the shift-amount width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 A  input  WIDTH  operand A.
REQ-009 B  input  WIDTH  operand B; B[SHW-1:0] is the shift amount for shift ops.
REQ-010 ALUControl  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 ZERO.
REQ-011 out_valid  output  1  Result and Flags are valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 Result  output  WIDTH  registered result.
REQ-014 Flags  output  4  registered {N, Z, C, V}.

Function
REQ-015 The block SHALL be an FSM with the states IDLE, SHIFT and DONE; it holds at most one operation in flight.
REQ-016 in_ready SHALL be 1 only in IDLE with rst_n high.
REQ-017 Accept occurs on a rising edge where in_valid && in_ready; A, B and ALUControl are captured on that edge.
REQ-018 While in_ready is 0, in_valid SHALL be ignored; the upstream must hold its request.
REQ-019 Non-shift ops: the result is computed on the accept edge and the FSM goes to DONE.
- out_valid SHALL be 1 in the first cycle after accept (latency 1).
REQ-020 Shift ops with n = B[SHW-1:0]:
- n = 0: the FSM goes directly to DONE with Result = A (latency 1).
- n > 0: the FSM enters SHIFT and shifts the working register by one bit per cycle, decrementing a counter.
- After the nth shift the FSM goes to DONE.
- out_valid SHALL be 1 exactly n+1 cycles after accept.
REQ-021 Shift fill SHALL be zero for both SHL and SHR; the maximum shift is WIDTH-1.
REQ-022 In DONE, Result, Flags and out_valid SHALL be held stable until out_valid && out_ready.
- On that edge the FSM goes to IDLE and out_valid drops.
- Accept is not possible in the same cycle.
REQ-023 Result and Flags SHALL retain the last completed value in IDLE and in SHIFT; they update only on entry to DONE.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH.
REQ-025 Flag N SHALL equal Result[WIDTH-1].
REQ-026 Flag Z SHALL be 1 when Result == 0.
REQ-027 Flag C:
- ADD: carry out.
- SUB: 1 when A >= B unsigned (no borrow).
- SHL/SHR: the last bit shifted out; 0 for n = 0.
- Other ops: 0.
REQ-028 Flag V: signed overflow for ADD and SUB; 0 for all other ops.
REQ-029 ZERO SHALL produce Result = 0 and Flags = 0100.

Reset
REQ-030 While rst_n is low, the block SHALL immediately and asynchronously set:
- state IDLE;
- Result 0 and Flags 0000;
- out_valid 0 and in_ready 0;
- shift counter 0.
REQ-031 Reset asserted mid-operation (SHIFT or DONE) SHALL abort the operation; no result is delivered.
REQ-032 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification (WIDTH=8)
REQ-033 A=0x0F, B=0x03, ADD -> Result 0x12, Flags 0000, out_valid 1 cycle after accept.
REQ-034 A=0x03, B=0x0F, SUB -> 0xF4, Flags 1000; A=0x80, B=0x01, SUB -> 0x7F, Flags 0011.
REQ-035 A=0x0F, B=0x03, SHL -> 0x78, C=0, out_valid 4 cycles after accept; A=0x81, B=0x01, SHL -> 0x02, C=1; A=0x0F, B=0x00, SHR -> 0x0F, latency 1.
REQ-036 ADD 0xFF+0x01 -> 0x00, Flags 0110; ZERO -> 0x00, Flags 0100; AND/OR/XOR of 0x0F and 0x03 -> 0x03/0x0F/0x0C.
REQ-037 Backpressure: out_ready low for 5 cycles in DONE with in_valid high -> Result/Flags stable, in_ready 0, no new accept; out_ready high -> IDLE next cycle.
REQ-038 rst_n pulsed low during SHL n=7 -> outputs zero immediately, out_valid never rises for the aborted op, in_ready 1 the cycle after release.
